// File: rtl/psg_pkg.sv
// Shared definitions for the PSG output stage: attenuation code width, the
// silent code and the one-step slew helper used by the attenuation ramp.
package psg_pkg;

    localparam int unsigned ATTEN_BITS   = 4;
    localparam int unsigned ATTEN_LEVELS = 1 << ATTEN_BITS;

    typedef logic [ATTEN_BITS-1:0] atten_t;

    localparam atten_t ATTEN_SILENT = atten_t'(15);

    // Move one code toward the target; holds when already there, so it can never overshoot.
    function automatic atten_t step_toward(input atten_t cur, input atten_t target);
        atten_t nxt;
        nxt = cur;
        if (cur < target) begin
            nxt = cur + atten_t'(1);
        end else if (cur > target) begin
            nxt = cur - atten_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/attenuation_lut.sv
// Combinational 2 dB-step volume table. Code 0 is full scale, codes 1..14 are
// full scale * 10^(-k/10) truncated (never below 1), code 15 or a low
// waveform bit gives silence. The table is built at elaboration time.
module attenuation_lut
    import psg_pkg::*;
#(
    parameter int unsigned VOLUME_BITS = 14
) (
    input  logic                   in,
    input  logic [ATTEN_BITS-1:0]  control,
    output logic [VOLUME_BITS-1:0] out
);

    localparam logic [VOLUME_BITS-1:0] MaxVol = {VOLUME_BITS{1'b1}};

    // Elaboration-time only: evaluates the dB curve for one table entry.
    function automatic logic [VOLUME_BITS-1:0] level_value(input int k);
        real r;
        int  v;
        r = real'(MaxVol) * (10.0 ** (-real'(k) / 10.0));
        v = $rtoi(r);
        if (v < 1) begin
            v = 1;
        end
        return VOLUME_BITS'(v);
    endfunction

    logic [VOLUME_BITS-1:0] level_table [ATTEN_LEVELS];

    for (genvar k = 0; k < ATTEN_LEVELS; k++) begin : g_table
        localparam logic [VOLUME_BITS-1:0] Level =
            (k == 0)                     ? MaxVol :
            (k == int'(ATTEN_SILENT))    ? '0     : level_value(k);
        assign level_table[k] = Level;
    end

    // Gate the table entry with the waveform bit.
    always_comb begin
        out = '0;
        if (in) begin
            out = level_table[control];
        end
    end

endmodule

// File: rtl/attenuation_mixer.sv
// Time-multiplexed attenuator/mixer. One shared volume LUT visits a channel
// per cycle; the per-channel levels are summed into one sample per frame.
// Each channel's attenuation optionally slews one step per ramp tick toward
// its programmed target to avoid zipper noise.
module attenuation_mixer
    import psg_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned VOLUME_BITS = 14,
    parameter int unsigned RAMP_PERIOD = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CHANNELS-1:0]                    in,
    input  logic [ATTEN_BITS*CHANNELS-1:0]         control,
    input  logic                                   ramp_en,
    output logic [ATTEN_BITS*CHANNELS-1:0]         atten,
    output logic [VOLUME_BITS+$clog2(CHANNELS)-1:0] out,
    output logic                                   out_valid
);

    localparam int unsigned ChBits  = $clog2(CHANNELS);
    localparam int unsigned SumBits = VOLUME_BITS + ChBits;
    localparam int unsigned PreBits = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;

    localparam logic [ChBits-1:0]  LastCh  = ChBits'(CHANNELS - 1);
    localparam logic [PreBits-1:0] LastPre = PreBits'(RAMP_PERIOD - 1);

    logic [ChBits-1:0]      ch;
    logic [SumBits-1:0]     acc;
    logic [PreBits-1:0]     prescaler;
    atten_t                 atten_reg  [CHANNELS];
    atten_t                 atten_next [CHANNELS];

    logic                   sel_in;
    atten_t                 sel_atten;
    logic [VOLUME_BITS-1:0] level;
    logic [SumBits-1:0]     frame_sum;
    logic                   tick;

    // Select the channel currently owning the shared LUT.
    always_comb begin
        sel_in    = in[ch];
        sel_atten = atten_reg[ch];
    end

    attenuation_lut #(
        .VOLUME_BITS (VOLUME_BITS)
    ) u_lut (
        .in      (sel_in),
        .control (sel_atten),
        .out     (level)
    );

    // Channel 0 starts a fresh frame; later channels add onto the running sum.
    always_comb begin
        frame_sum = SumBits'(level);
        if (ch != '0) begin
            frame_sum = acc + SumBits'(level);
        end
    end

    // Channel pointer, accumulator and the per-frame output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch        <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            acc       <= frame_sum;
            out_valid <= 1'b0;
            if (ch == LastCh) begin
                ch        <= '0;
                out       <= frame_sum;
                out_valid <= 1'b1;
            end else begin
                ch <= ch + ChBits'(1);
            end
        end
    end

    assign tick = (prescaler == LastPre);

    // Free-running ramp prescaler; it keeps counting even when ramping is off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PreBits'(1);
        end
    end

    // Next attenuation: follow the target directly, or slew one step per tick.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            atten_next[c] = atten_reg[c];
            if (!ramp_en) begin
                atten_next[c] = control[c*ATTEN_BITS +: ATTEN_BITS];
            end else if (tick) begin
                atten_next[c] = step_toward(atten_reg[c],
                                            control[c*ATTEN_BITS +: ATTEN_BITS]);
            end
        end
    end

    // Per-channel attenuation registers; reset to silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                atten_reg[c] <= ATTEN_SILENT;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                atten_reg[c] <= atten_next[c];
            end
        end
    end

    // Pack the current attenuation for observation.
    always_comb begin
        atten = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            atten[c*ATTEN_BITS +: ATTEN_BITS] = atten_reg[c];
        end
    end

endmodule

// File: tb/tb_attenuation_mixer.sv
// Self-checking bench for attenuation_mixer (4 channels, 14-bit volume,
// ramp period 8). A frame-level reference model predicts atten, out and
// out_valid every cycle; directed scenarios add fixed expected values.
module tb_attenuation_mixer;

    localparam int CH  = 4;
    localparam int VB  = 14;
    localparam int RP  = 8;
    localparam int OW  = VB + 2;
    localparam int MAX = 16383;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] in_bits;
    logic [15:0]   control;
    logic          ramp_en;
    logic [15:0]   atten;
    logic [OW-1:0] out;
    logic          out_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_atten [CH];
    int m_sum;
    int m_out;
    bit m_valid;
    int edge_n;

    always #5 clk = ~clk;

    attenuation_mixer #(
        .CHANNELS    (CH),
        .VOLUME_BITS (VB),
        .RAMP_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_bits),
        .control   (control),
        .ramp_en   (ramp_en),
        .atten     (atten),
        .out       (out),
        .out_valid (out_valid)
    );

    function automatic int lut_ref(input logic b, input int k);
        real r;
        int  v;
        if (!b || k == 15) return 0;
        if (k == 0) return MAX;
        r = 16383.0 * (10.0 ** (-real'(k) / 10.0));
        v = $rtoi(r);
        if (v < 1) v = 1;
        return v;
    endfunction

    function automatic logic [15:0] model_atten_packed();
        logic [15:0] p;
        for (int k = 0; k < CH; k++) p[4*k +: 4] = 4'(m_atten[k]);
        return p;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic [3:0] i, input logic [15:0] c, input logic re,
                        input logic rn);
        int ch;
        int v;
        int tgt;
        logic [15:0] exp_atten;
        @(negedge clk);
        in_bits = i;
        control = c;
        ramp_en = re;
        rst_n   = rn;
        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < CH; k++) m_atten[k] = 15;
            m_sum   = 0;
            m_out   = 0;
            m_valid = 0;
            edge_n  = 0;
        end else begin
            edge_n++;
            ch = (edge_n - 1) % CH;
            v  = lut_ref(i[ch], m_atten[ch]);
            m_sum = (ch == 0) ? v : m_sum + v;
            if (ch == CH - 1) begin
                m_out   = m_sum;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            for (int k = 0; k < CH; k++) begin
                tgt = int'(c[4*k +: 4]);
                if (!re) m_atten[k] = tgt;
                else if (edge_n % RP == 0) begin
                    if (m_atten[k] < tgt) m_atten[k]++;
                    else if (m_atten[k] > tgt) m_atten[k]--;
                end
            end
        end
        #1;
        exp_atten = model_atten_packed();
        checks++;
        if (atten !== exp_atten) begin
            $display("FAIL model_atten t=%0t: got %h expected %h", $time, atten, exp_atten);
            errors++;
        end
        checks++;
        if (out_valid !== m_valid) begin
            $display("FAIL model_valid t=%0t: got %b expected %b", $time, out_valid, m_valid);
            errors++;
        end
        checks++;
        if (out !== OW'(m_out)) begin
            $display("FAIL model_out t=%0t: got %0d expected %0d", $time, out, m_out);
            errors++;
        end
    endtask

    task automatic test_reset;
        step(4'hF, 16'h0000, 1'b0, 1'b0);
        step(4'hA, 16'h1234, 1'b1, 1'b0);
        checks++;
        if (atten !== 16'hFFFF || out !== '0 || out_valid !== 1'b0) begin
            $display("FAIL reset_state: atten=%h out=%0d valid=%b expected ffff/0/0",
                     atten, out, out_valid);
            errors++;
        end
    endtask

    task automatic test_full_volume;
        step(4'hF, 16'h0000, 1'b0, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            step(4'hF, 16'h0000, 1'b0, 1'b1);
            checks++;
            if (out_valid !== (n % 4 == 0)) begin
                $display("FAIL pulse_spacing edge %0d: got %b expected %b",
                         n, out_valid, (n % 4 == 0));
                errors++;
            end
            // ch0 is sampled while its atten still holds the reset value 15
            if (n == 4) begin
                checks++;
                if (out !== OW'(3 * MAX)) begin
                    $display("FAIL first_frame: got %0d expected %0d", out, 3 * MAX);
                    errors++;
                end
            end else if (n % 4 == 0) begin
                checks++;
                if (out !== OW'(65532)) begin
                    $display("FAIL full_volume: got %0d expected 65532", out);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_in_change;
        step(4'hB, 16'h0000, 1'b0, 1'b1);
        while (edge_n % 4 != 0) step(4'hB, 16'h0000, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step(4'hB, 16'h0000, 1'b0, 1'b1);
            if (out_valid) begin
                checks++;
                if (out !== OW'(49149)) begin
                    $display("FAIL in_1011: got %0d expected 49149", out);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_mixed_levels;
        step(4'hF, 16'hE210, 1'b0, 1'b1);
        while (edge_n % 4 != 0) step(4'hF, 16'hE210, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step(4'hF, 16'hE210, 1'b0, 1'b1);
            if (out_valid) begin
                checks++;
                if (out !== OW'(40384)) begin
                    $display("FAIL mixed_levels: got %0d expected 40384", out);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_ramp_down;
        int exp0;
        step(4'hF, 16'hFFF0, 1'b1, 1'b0);
        for (int n = 1; n <= 136; n++) begin
            step(4'hF, 16'hFFF0, 1'b1, 1'b1);
            exp0 = 15 - n / RP;
            if (exp0 < 0) exp0 = 0;
            checks++;
            if (atten !== {12'hFFF, 4'(exp0)}) begin
                $display("FAIL ramp_down edge %0d: got %h expected %h",
                         n, atten, {12'hFFF, 4'(exp0)});
                errors++;
            end
        end
    endtask

    task automatic test_retarget;
        int budget = 0;
        step(4'hF, 16'hFFF0, 1'b1, 1'b0);
        while (m_atten[0] != 10 && budget < 200) begin
            step(4'hF, 16'hFFF0, 1'b1, 1'b1);
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            $display("FAIL retarget_reach: got budget %0d expected < 200", budget);
            errors++;
        end
        step(4'hF, 16'hFFFC, 1'b1, 1'b1);
        while (edge_n % RP != 0) step(4'hF, 16'hFFFC, 1'b1, 1'b1);
        checks++;
        if (atten[3:0] !== 4'd11) begin
            $display("FAIL retarget_tick1: got %0d expected 11", atten[3:0]);
            errors++;
        end
        for (int n = 0; n < RP; n++) step(4'hF, 16'hFFFC, 1'b1, 1'b1);
        checks++;
        if (atten[3:0] !== 4'd12) begin
            $display("FAIL retarget_tick2: got %0d expected 12", atten[3:0]);
            errors++;
        end
        for (int n = 0; n < 3 * RP; n++) step(4'hF, 16'hFFFC, 1'b1, 1'b1);
        checks++;
        if (atten[3:0] !== 4'd12) begin
            $display("FAIL retarget_hold: got %0d expected 12", atten[3:0]);
            errors++;
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] c;
        c = 16'($urandom);
        for (int n = 0; n < 13; n++) step(4'($urandom), c, 1'b1, 1'b1);
        step(4'($urandom), c, 1'b1, 1'b0);
        checks++;
        if (atten !== 16'hFFFF || out !== '0 || out_valid !== 1'b0) begin
            $display("FAIL reset_mid: atten=%h out=%0d valid=%b expected ffff/0/0",
                     atten, out, out_valid);
            errors++;
        end
        for (int n = 1; n <= 4; n++) begin
            step(4'($urandom), c, 1'b1, 1'b1);
            checks++;
            if (out_valid !== (n == 4)) begin
                $display("FAIL reset_mid_pulse edge %0d: got %b expected %b",
                         n, out_valid, (n == 4));
                errors++;
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] c;
        logic        re;
        c  = 16'($urandom);
        re = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 29) == 0) c = 16'($urandom);
            if ($urandom_range(0, 49) == 0) re = ~re;
            step(4'($urandom), c, re, ($urandom_range(0, 249) != 0));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_bits = '0;
        control = '0;
        ramp_en = 1'b0;
        test_reset();
        test_full_volume();
        test_in_change();
        test_mixed_levels();
        test_ramp_down();
        test_retarget();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
